lvds_tx_gen: RTL and testbench

Test-pattern source for the 2-lane LVDS link. It serialises bytes onto lvds_data0/lvds_data1 with a frame-enable lvds_flag, using the same bit order and frame framing the receive stage deserialises into 8-bit AXI-stream bytes. It is used for loopback on the ZC706 board and to drive the receiver in simulation. All line outputs come from registers clocked by clk.

---
 rtl/lvds_tx_gen.sv | 138 +++++++++++++
 tb/tb_lvds_tx_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_gen.sv
// Test-pattern source for the 2-lane LVDS link: serialises incrementing or PRBS-8
// bytes as two LSB-first nibbles per byte, framed by lvds_flag, in bursts of frames.
module lvds_tx_gen #(
  parameter int FRAME_BYTES = 896,
  parameter int GAP_CYCLES  = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] burst_len,
  output logic             lvds_data0,
  output logic             lvds_data1,
  output logic             lvds_flag,
  output logic             busy,
  output logic [31:0]      frames_sent,
  output logic             done
);

  localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]        LFSR_SEED = 8'hFF;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [1:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        frame_idx;
  logic [7:0]        lfsr;
  logic              mode_q;
  logic [CNT_W-1:0]  burst_len_q;
  logic              stop_pending;
  logic              last_bit;
  logic              gap_end;
  logic              burst_end;
  logic [7:0]        cur_byte;

  always_comb begin
    last_bit  = (state == SEND) && (bit_cnt == 2'd3) && (byte_cnt == LAST_BYTE);
    gap_end   = (state == GAP) && (gap_cnt == LAST_GAP);
    burst_end = stop_pending ||
                ((burst_len_q != '0) && (frames_sent == 32'(burst_len_q)));
    cur_byte  = mode_q ? lfsr : (frame_idx + 8'(byte_cnt));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (last_bit) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = burst_end ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame/byte/bit counters, payload generator and burst bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      frame_idx    <= '0;
      lfsr         <= LFSR_SEED;
      mode_q       <= 1'b0;
      burst_len_q  <= '0;
      stop_pending <= 1'b0;
      frames_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A stop coinciding with start limits the burst to one frame.
          stop_pending <= start & stop;
          if (start) begin
            mode_q      <= mode;
            burst_len_q <= burst_len;
            frames_sent <= '0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            frame_idx   <= '0;
            lfsr        <= LFSR_SEED;
          end
        end
        SEND: begin
          stop_pending <= stop_pending | stop;
          bit_cnt      <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            if (last_bit) begin
              byte_cnt    <= '0;
              lfsr        <= LFSR_SEED;
              frames_sent <= frames_sent + 32'd1;
              frame_idx   <= frame_idx + 8'd1;
              gap_cnt     <= '0;
            end else begin
              byte_cnt <= byte_cnt + BYTE_W'(1);
              lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_end && burst_end) stop_pending <= 1'b0;
          else                      stop_pending <= stop_pending | stop;
        end
        default: stop_pending <= 1'b0;
      endcase
    end
  end

  // Line outputs lag the counters by one cycle so every pin is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvds_flag  <= 1'b0;
      lvds_data0 <= 1'b0;
      lvds_data1 <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lvds_flag  <= (state == SEND);
      lvds_data0 <= (state == SEND) && cur_byte[{1'b0, bit_cnt}];
      lvds_data1 <= (state == SEND) && cur_byte[{1'b1, bit_cnt}];
      busy       <= (state_nxt != IDLE);
      done       <= (state == GAP) && (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_lvds_tx_gen.sv
// Bench for lvds_tx_gen: a small-frame instance checked byte-by-byte against a
// scoreboard queue, plus a default-parameter instance for full-length frames.
module tb_lvds_tx_gen;

  localparam int FB  = 4;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, stop, mode;
  logic [15:0] burst_len;
  logic        d0, d1, flag, busy, done;
  logic [31:0] frames_sent;

  logic        b_start, b_stop, b_mode;
  logic [15:0] b_burst_len;
  logic        b_d0, b_d1, b_flag, b_busy, b_done;
  logic [31:0] b_frames;

  always #5 clk = ~clk;

  lvds_tx_gen #(.FRAME_BYTES(FB), .GAP_CYCLES(GAP), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .lvds_data0(d0), .lvds_data1(d1), .lvds_flag(flag),
    .busy(busy), .frames_sent(frames_sent), .done(done)
  );

  lvds_tx_gen u_dut_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .mode(b_mode),
    .burst_len(b_burst_len), .lvds_data0(b_d0), .lvds_data1(b_d1), .lvds_flag(b_flag),
    .busy(b_busy), .frames_sent(b_frames), .done(b_done)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic push_burst(input logic m, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      logic [7:0] s;
      s = 8'hFF;
      for (int b = 0; b < FB; b++) begin
        if (m) begin
          exp_q.push_back(s);
          s = lfsr_step(s);
        end else begin
          exp_q.push_back(8'(f + b));
        end
      end
    end
  endtask

  // Small-instance monitor: deserialise bytes, check flag windows and gaps.
  logic [7:0] mon_byte;
  int         mon_bit = 0, hi_run = 0, lo_run = 0;
  logic       win_seen = 1'b0, flag_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bit = 0; hi_run = 0; lo_run = 0; win_seen = 1'b0; flag_prev = 1'b0;
    end else begin
      if (flag) begin
        if (!flag_prev && win_seen) check("gap_len", lo_run, GAP);
        mon_byte[mon_bit]     = d0;
        mon_byte[mon_bit + 4] = d1;
        mon_bit++;
        hi_run++;
        lo_run = 0;
        if (mon_bit == 4) begin
          mon_bit = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_extra: got 0x%0h, expected no byte", mon_byte);
          end else begin
            check("byte", mon_byte, exp_q.pop_front());
          end
        end
      end else begin
        if (flag_prev) begin
          check("flag_len", hi_run, FB * 4);
          win_seen = 1'b1;
        end
        check("idle_lines", {d1, d0}, 0);
        hi_run = 0;
        mon_bit = 0;
        lo_run++;
        if (!busy) win_seen = 1'b0;
      end
      flag_prev = flag;
    end
  end

  // Default-parameter monitor: record run length and last byte of two windows.
  int         big_run[2];
  logic [7:0] big_last[2];
  int         big_win = 0, brun = 0, bbit = 0;
  logic [7:0] bbyte;

  always @(negedge clk) begin
    if (!rst_n) begin
      brun = 0; bbit = 0;
    end else if (b_flag) begin
      bbyte[bbit]     = b_d0;
      bbyte[bbit + 4] = b_d1;
      bbit = (bbit + 1) % 4;
      brun++;
    end else begin
      if (brun != 0 && big_win < 2) begin
        big_run[big_win]  = brun;
        big_last[big_win] = bbyte;
        big_win++;
      end
      brun = 0;
      bbit = 0;
    end
  end

  task automatic start_burst(input logic m, input logic [15:0] bl, input logic stp);
    @(negedge clk);
    mode = m; burst_len = bl; start = 1'b1; stop = stp;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; mode = ~m; burst_len = 16'd7;
    check("lat_busy", busy, 1);
    check("lat_flag_low", flag, 0);
    @(negedge clk);
    check("lat_flag_high", flag, 1);
  endtask

  task automatic wait_done(input int exp_frames);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(negedge clk);
      got = done;
    end
    check("done_seen", got, 1);
    if (got) begin
      check("busy_at_done", busy, 0);
      check("frames_at_done", frames_sent, exp_frames);
      @(negedge clk);
      check("done_pulse", done, 0);
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_cond(input string name, input int which);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (which == 0) got = (frames_sent == 32'd4) && !flag;
      else            got = flag;
    end
    check(name, got, 1);
  endtask

  typedef struct {
    logic        m;
    logic [15:0] bl;
    int          exp_frames;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [3:0] s0, s1;
    bit         got;

    vecs[0] = '{1'b0, 16'd1, 1};
    vecs[1] = '{1'b0, 16'd3, 3};
    vecs[2] = '{1'b1, 16'd4, 4};
    vecs[3] = '{1'b1, 16'd1, 1};
    vecs[4] = '{1'b0, 16'd2, 2};

    start = 1'b0; stop = 1'b0; mode = 1'b0; burst_len = '0;
    b_start = 1'b0; b_stop = 1'b0; b_mode = 1'b0; b_burst_len = '0;

    repeat (3) @(negedge clk);
    check("reset_lines", {flag, d0, d1, busy, done}, 0);
    check("reset_frames", frames_sent, 0);
    rst_n = 1'b1;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_stop_ignored", {busy, flag}, 0);

    for (int i = 0; i < 5; i++) begin
      push_burst(vecs[i].m, vecs[i].exp_frames);
      start_burst(vecs[i].m, vecs[i].bl, 1'b0);
      wait_done(vecs[i].exp_frames);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // PRBS byte 1 (0xFE) on the lanes: nibble bits LSB first.
    push_burst(1'b1, 1);
    start_burst(1'b1, 16'd1, 1'b0);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      s0[k] = d0;
      s1[k] = d1;
      @(negedge clk);
    end
    check("fe_lane0", s0, 4'b1110);
    check("fe_lane1", s1, 4'b1111);
    wait_done(1);

    // start and stop together: exactly one frame.
    push_burst(1'b0, 1);
    start_burst(1'b0, 16'd5, 1'b1);
    wait_done(1);

    // Continuous burst, stop mid frame 5, stray starts ignored.
    push_burst(1'b0, 5);
    start_burst(1'b0, 16'd0, 1'b0);
    wait_cond("reach_frame4_end", 0);
    wait_cond("reach_frame5", 1);
    repeat (6) @(negedge clk);
    stop = 1'b1; start = 1'b1; mode = 1'b1; burst_len = 16'd1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    check("frames_mid_frame5", frames_sent, 4);
    check("flag_after_stop", flag, 1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5);

    // Reset at bit 2 of byte 1.
    push_burst(1'b0, 1);
    start_burst(1'b0, 16'd1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_flag", flag, 1);
    rst_n = 1'b0;
    #1;
    check("reset_async_lines", {flag, d0, d1, busy, done}, 0);
    check("reset_async_frames", frames_sent, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_idle", {flag, busy, done}, 0);
    push_burst(1'b0, 1);
    start_burst(1'b0, 16'd1, 1'b0);
    wait_done(1);

    // Default parameters: 3584-cycle windows, last byte wraps mod 256.
    @(negedge clk);
    b_mode = 1'b0; b_burst_len = 16'd2; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10000 && !got; k++) begin
      @(negedge clk);
      got = b_done;
    end
    check("big_done_seen", got, 1);
    check("big_windows", big_win, 2);
    check("big_run0", big_run[0], 3584);
    check("big_run1", big_run[1], 3584);
    check("big_last0", big_last[0], 8'h7F);
    check("big_last1", big_last[1], 8'h80);
    check("big_frames", b_frames, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
